// File: rtl/systolic_seq_ctrl.sv
// Control sequencer for a weight-stationary NxN MAC array: clear, load weight rows,
// stream skewed activations, flag skewed result columns. Control signals only.
module systolic_seq_ctrl #(
    parameter int DATA_SIZE  = 8,
    parameter int ARRAY_SIZE = 2,
    parameter int VEC_W      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [VEC_W-1:0]              num_vec,
    output logic                          busy,
    output logic                          done,
    output logic                          start_err,
    output logic                          array_clr,
    output logic [ARRAY_SIZE-1:0]         w_load,
    output logic [$clog2(ARRAY_SIZE)-1:0] w_row_idx,
    output logic                          a_rd_en,
    output logic [ARRAY_SIZE-1:0]         a_lane_vld,
    output logic [ARRAY_SIZE-1:0]         res_col_vld
);

    localparam int RW = $clog2(ARRAY_SIZE);
    // Holds M + 2N - 2 for the largest M with headroom, so the stream counter never wraps.
    localparam int CW = VEC_W + $clog2(ARRAY_SIZE) + 2;

    if (DATA_SIZE < 1 || ARRAY_SIZE < 2) begin : g_bad_param
        $error("systolic_seq_ctrl: DATA_SIZE must be >= 1 and ARRAY_SIZE >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [RW-1:0]           r_row, w_row_nxt;
    logic [CW-1:0]           r_t, w_t_nxt;
    logic [VEC_W-1:0]        r_m, w_m_nxt;
    logic [CW-1:0]           w_t_last;
    logic [CW-1:0]           w_m_ext;
    logic                    w_stream;

    logic                    r_busy, r_done, r_err, r_clr, r_rd;
    logic [ARRAY_SIZE-1:0]   r_wl, r_lane, r_col;
    logic [RW-1:0]           r_idx;

    logic                    w_busy_nxt, w_done_nxt, w_err_nxt, w_clr_nxt, w_rd_nxt;
    logic [ARRAY_SIZE-1:0]   w_wl_nxt, w_lane_nxt, w_col_nxt;
    logic [RW-1:0]           w_idx_nxt;

    assign w_t_last = CW'(r_m) + CW'(2 * ARRAY_SIZE - 2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_row   <= '0;
            r_t     <= '0;
            r_m     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_t     <= w_t_nxt;
            r_m     <= w_m_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = '0;
        w_t_nxt     = '0;
        w_m_nxt     = r_m;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (num_vec != '0) begin
                        w_state_nxt = S_CLEAR;
                        w_m_nxt     = num_vec;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_CLEAR: w_state_nxt = S_LOAD;
            S_LOAD: begin
                if (r_row == RW'(ARRAY_SIZE - 1)) w_state_nxt = S_STREAM;
                else                              w_row_nxt   = r_row + RW'(1);
            end
            S_STREAM: begin
                if (r_t == w_t_last) w_state_nxt = S_DONE;
                else                 w_t_nxt     = r_t + CW'(1);
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state/counters and registered, so each one
    // lines up with the state it belongs to and nothing is combinational from inputs.
    always_comb begin
        w_stream   = (w_state_nxt == S_STREAM);
        w_m_ext    = CW'(r_m);
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (w_state_nxt == S_DONE);
        w_clr_nxt  = (w_state_nxt == S_CLEAR);
        w_rd_nxt   = w_stream && (w_t_nxt < w_m_ext);
        w_idx_nxt  = (w_state_nxt == S_LOAD) ? w_row_nxt : '0;
        w_wl_nxt   = '0;
        w_lane_nxt = '0;
        w_col_nxt  = '0;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            w_wl_nxt[i]   = (w_state_nxt == S_LOAD) && (w_row_nxt == RW'(i));
            w_lane_nxt[i] = w_stream && (w_t_nxt >= CW'(i)) && (w_t_nxt < CW'(i) + w_m_ext);
            w_col_nxt[i]  = w_stream && (w_t_nxt >= CW'(ARRAY_SIZE + i))
                            && (w_t_nxt < CW'(ARRAY_SIZE + i) + w_m_ext);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_clr  <= 1'b0;
            r_rd   <= 1'b0;
            r_wl   <= '0;
            r_idx  <= '0;
            r_lane <= '0;
            r_col  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;
            r_clr  <= w_clr_nxt;
            r_rd   <= w_rd_nxt;
            r_wl   <= w_wl_nxt;
            r_idx  <= w_idx_nxt;
            r_lane <= w_lane_nxt;
            r_col  <= w_col_nxt;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign start_err   = r_err;
    assign array_clr   = r_clr;
    assign w_load      = r_wl;
    assign w_row_idx   = r_idx;
    assign a_rd_en     = r_rd;
    assign a_lane_vld  = r_lane;
    assign res_col_vld = r_col;

endmodule
